fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side controller for the team's 8-bit, 16-deep synchronous FIFO.
- Drives the FIFO read enable from the FIFO empty flag and absorbs the FIFO's one-cycle registered read latency.
- Presents the popped bytes downstream as a valid/ready byte stream, with frame-end marking every FRAME_LEN bytes.
- Sits between the FIFO's read port and any byte consumer, such as a serializer or a packet builder.

Parameters:
- FRAME_LEN, 4, number of bytes per frame. Legal range 1..65535. m_last marks the final byte of each frame.
- BUF_DEPTH, 3, entries in the internal holding buffer. Fixed at 3; this is the minimum depth for full throughput without a combinational m_ready-to-fifo_rd_en path.

Ports:
- clk  in  1  clock. All logic updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enable  in  1  when high, the block may issue new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO registered read data. It is valid in the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read enable (combinational).
- m_data  out  8  downstream byte (head of the holding buffer).
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  m_data is the last byte of a frame. Qualified by m_valid.
- byte_count  out  16  total bytes handed off since reset.
- busy  out  1  high when the buffer is non-empty or a read is in flight.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low.
- Reset (reset==0 at a rising edge):
  - Buffer occupancy, in-flight flag, frame index, byte_count and the buffer pointers clear to 0; m_data clears to 8'h00.
  - m_valid=0, m_last=0, busy=0.
  - fifo_rd_en is forced to 0 for as long as reset is low.
  - A reset mid-operation discards buffered and in-flight bytes; no output is produced for them.
- Internal state:
  - occ: buffer occupancy, 0..3.
  - inflight: 1 if a read was accepted by the FIFO in the previous cycle.
  - frame_idx: position within the current frame, 0..FRAME_LEN-1.
- Read issue:
  - fifo_rd_en = reset && enable && !fifo_empty && (occ + inflight < 3).
  - fifo_rd_en depends only on registered state plus fifo_empty and enable, never on m_ready.
  - A read is accepted when fifo_rd_en is high; the FIFO ignores rd_en when empty, and fifo_rd_en is never driven high while fifo_empty is high.
  - inflight(next) = fifo_rd_en.
- Capture: in any cycle with inflight==1, fifo_data is written into the buffer tail at the rising edge ending that cycle.
- Latency: fifo_rd_en in cycle t gives fifo_data valid in cycle t+1 and m_valid in cycle t+2 (two cycles minimum).
- Throughput: with m_ready held high and the FIFO non-empty, one byte per cycle in steady state (occ=1, inflight=1).
- Output handshake:
  - m_valid = (occ != 0); m_data = buffer head.
  - A transfer occurs when m_valid && m_ready. The head pops at that edge and the next entry (or the simultaneously captured byte) becomes head.
  - m_data and m_valid are stable while m_valid && !m_ready.
  - Simultaneous capture and pop in one cycle: occ is unchanged and the byte order is preserved.
- Overflow: impossible by construction. The occ + inflight < 3 rule guarantees a free slot for every in-flight byte even when m_ready is low.
- Framing:
  - m_last = m_valid && (frame_idx == FRAME_LEN-1).
  - On each transfer, frame_idx increments, wrapping to 0 after FRAME_LEN-1.
  - FRAME_LEN=1 gives m_last=1 on every valid byte.
- byte_count: increments by 1 on each transfer and wraps from 16'hFFFF to 16'h0000.
- enable low: no new reads are issued. An in-flight byte is still captured and buffered bytes are still delivered. frame_idx is not cleared, so a frame may span enable gaps.
- FIFO goes empty mid-stream: reads stop; m_valid drops once the buffer drains; the stream resumes when fifo_empty falls.
- busy = (occ != 0) || inflight.

Test Plan:
- Reset, then the FIFO is written with 8'h11,8'h22,8'h33 while enable=1 and m_ready=1 -> fifo_rd_en pulses 3 times. m_data sequence 11,22,33 with m_valid first high 2 cycles after the first rd_en. m_last on no byte; byte_count=3.
- FIFO holds 16 bytes 0x00..0x0F, FRAME_LEN=4, m_ready=1 -> 16 transfers on consecutive cycles after the 2-cycle fill. m_last with bytes 03,07,0B,0F. byte_count=16. FIFO empty at the end; busy=0 one cycle after the last transfer.
- Same 16 bytes; m_ready low for cycles 3..10 -> no more than 3 bytes are buffered. fifo_rd_en is 0 while occ+inflight=3. No byte is lost or duplicated; output order is 00..0F.
- enable dropped for 5 cycles mid-stream after byte 05 -> fifo_rd_en=0 during the gap. The byte already in flight is delivered. The stream continues 06.. after enable returns, and frame_idx continues across the gap (m_last still at 07).
- reset driven low for 1 cycle while occ=2 and inflight=1 -> the next cycle shows m_valid=0, busy=0, byte_count=0, m_data=00. fifo_rd_en=0 during the reset cycle.
- byte_count preset by streaming 65536 bytes -> byte_count wraps to 0x0000 on the 65536th transfer.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Purpose  : Bundles the FIFO read port and the downstream byte stream used
//            by fifo_stream_reader.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   fifo_empty  FIFO empty flag                       (FIFO   -> reader)
//   fifo_data   FIFO registered read data, 8 bits     (FIFO   -> reader)
//   fifo_rd_en  FIFO read enable                      (reader -> FIFO)
//   m_data      downstream byte, 8 bits               (reader -> consumer)
//   m_valid     m_data is valid                       (reader -> consumer)
//   m_ready     consumer accepts the byte             (consumer -> reader)
//   m_last      last byte of a frame                  (reader -> consumer)
// Modports:
//   master  the reader side (drives rd_en and the stream)
//   slave   the FIFO/consumer side
// ============================================================================
interface fifo_stream_reader_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Read-side controller for an 8-bit synchronous FIFO with a
//            one-cycle registered read latency. Pops bytes whenever there is
//            room for them, holds them in a small buffer and presents them as
//            a valid/ready byte stream with frame-end marking.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   FRAME_LEN   bytes per frame (1..65535); m_last flags the final byte
//   BUF_DEPTH   holding buffer entries; must stay 3
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-low reset
//   enable      allows new FIFO reads to be issued
//   bus         master side of fifo_stream_reader_if (FIFO read port and
//               downstream stream)
//   byte_count  bytes handed off since reset, wraps at 16 bits
//   busy        buffer non-empty or a read in flight
// ============================================================================
module fifo_stream_reader #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_stream_reader_if.master  bus,
  output logic [15:0]           byte_count,
  output logic                  busy
);

  localparam int unsigned PTR_W    = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [OCC_W:0]   DEPTH_LVL = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);

  // Holding buffer and its bookkeeping
  logic [7:0]       mem_q [BUF_DEPTH];
  logic [7:0]       mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [15:0]      frame_idx_q, frame_idx_d;
  logic [15:0]      byte_count_q, byte_count_d;

  logic             rd_en;
  logic             pop;
  logic [OCC_W:0]   level;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Slots already committed: bytes held plus the byte arriving next cycle.
  // Reads are only issued while a slot is still uncommitted, so a byte in
  // flight always has somewhere to land even if the consumer stalls. Using
  // registered occupancy (not m_ready) keeps rd_en off the downstream path.
  assign level = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};

  always_comb begin
    rd_en        = reset && enable && !bus.fifo_empty && (level < DEPTH_LVL);
    pop          = (occ_q != '0) && bus.m_ready;

    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    frame_idx_d  = frame_idx_q;
    byte_count_d = byte_count_q;
    inflight_d   = rd_en;

    // FIFO data is valid the cycle after an accepted read
    if (inflight_q) begin
      mem_d[wr_ptr_q] = bus.fifo_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d     = ptr_inc(rd_ptr_q);
      byte_count_d = byte_count_q + 16'd1;
      frame_idx_d  = (frame_idx_q == LAST_IDX) ? 16'd0 : frame_idx_q + 16'd1;
    end

    // Capture and pop in the same cycle leave occupancy unchanged
    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      frame_idx_q  <= 16'd0;
      byte_count_q <= 16'd0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      frame_idx_q  <= frame_idx_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = mem_q[rd_ptr_q];
  assign bus.m_valid    = (occ_q != '0);
  assign bus.m_last     = (occ_q != '0) && (frame_idx_q == LAST_IDX);
  assign byte_count     = byte_count_q;
  assign busy           = (occ_q != '0) || inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. A behavioural FIFO
//            feeds the reader; every byte written is also pushed, with its
//            expected frame-end flag, into a scoreboard queue that a monitor
//            pops whenever the reader hands a byte off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int FRAME_LEN = 4;
  localparam int FIFO_CAP  = 16;
  localparam int MAX_LVL   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] byte_count;
  logic        busy;

  fifo_stream_reader_if bus ();

  fifo_stream_reader #(
    .FRAME_LEN (FRAME_LEN),
    .BUF_DEPTH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .byte_count (byte_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]  fifo_q[$];       // contents of the behavioural FIFO
  logic [8:0]  exp_q[$];        // scoreboard: {last, data} in delivery order
  int          sent_cnt    = 0; // bytes written since reset (frame position)
  int          outstanding = 0; // bytes popped from the FIFO, not yet delivered
  int          model_inflight = 0;
  logic [15:0] exp_bc      = 16'd0;
  int          delivered   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back({((sent_cnt % FRAME_LEN) == FRAME_LEN - 1), b});
    sent_cnt++;
  endtask

  // Behavioural FIFO plus the reader's expected transaction counts.
  // The empty flag is registered, so bytes written in a cycle become
  // visible at the following edge.
  always @(posedge clk) begin : model
    int rd;
    int xfer;
    if (!reset) begin
      fifo_q.delete();
      exp_q.delete();
      sent_cnt       = 0;
      outstanding    = 0;
      model_inflight = 0;
      exp_bc         = 16'd0;
      delivered      = 0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_data  <= 8'h00;
    end else begin
      rd   = (enable && !bus.fifo_empty && outstanding < MAX_LVL) ? 1 : 0;
      xfer = (outstanding > model_inflight && bus.m_ready) ? 1 : 0;
      if (rd != 0) bus.fifo_data <= fifo_q.pop_front();
      bus.fifo_empty <= (fifo_q.size() == 0);
      if (xfer != 0) begin
        exp_bc    = exp_bc + 16'd1;
        delivered = delivered + 1;
      end
      outstanding    = outstanding + rd - xfer;
      model_inflight = rd;
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each hand-off
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin : monitor
    logic exp_rd;
    logic exp_valid;
    exp_rd    = reset && enable && !bus.fifo_empty && (outstanding < MAX_LVL);
    exp_valid = (outstanding > model_inflight);
    chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(outstanding != 0));
    chk("byte_count", 32'(byte_count), 32'(exp_bc));
    if (hold_prev) chk("hold_stable", 32'({bus.m_valid, bus.m_data}), 32'({1'b1, hold_data}));
    if (bus.m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(bus.m_data), 32'hFFFF_FFFF);
      end else begin
        chk("m_data", 32'(bus.m_data), 32'(exp_q[0][7:0]));
        chk("m_last", 32'(bus.m_last), 32'(exp_q[0][8]));
        if (bus.m_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("m_last_idle", 32'(bus.m_last), 32'd0);
    end
    hold_prev = bus.m_valid && !bus.m_ready && reset;
    hold_data = bus.m_data;
  end

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("reset_m_data", 32'(bus.m_data), 32'h00);
    chk("reset_byte_count", 32'(byte_count), 32'd0);
  endtask

  task automatic wait_drain(input int limit, output int n);
    n = 0;
    while ((fifo_q.size() != 0 || outstanding != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    int pushed;
    reset       = 1'b0;
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("init_m_data", 32'(bus.m_data), 32'h00);
    chk("init_busy", 32'(busy), 32'd0);

    // Three bytes, checking the two-cycle rd_en -> m_valid latency
    enable = 1'b1;
    bus.m_ready = 1'b1;
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.fifo_rd_en && n < 10);
    chk("p1_rd_seen", 32'(bus.fifo_rd_en), 32'd1);
    tick();
    chk("p1_valid_lat1", 32'(bus.m_valid), 32'd0);
    tick();
    chk("p1_valid_lat2", 32'({bus.m_valid, bus.m_data}), 32'h111);
    wait_drain(50, n);
    tick();
    chk("p1_byte_count", 32'(byte_count), 32'd3);

    // 16 bytes back to back at full rate
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) fifo_push(8'(i));
    tick();
    enable = 1'b1;
    wait_drain(100, n);
    chk("p2_drain_cycles", 32'(n), 32'd18);
    chk("p2_byte_count", 32'(byte_count), 32'd16);
    chk("p2_busy_idle", 32'(busy), 32'd0);

    // Consumer stall during cycles 3..10
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) fifo_push(8'(i));
    tick();
    enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      bus.m_ready = !(c >= 3 && c <= 10);
      if (fifo_q.size() == 0 && outstanding == 0 && c > 0) break;
      tick();
    end
    bus.m_ready = 1'b1;
    chk("p3_byte_count", 32'(byte_count), 32'd16);

    // enable gap of 5 cycles after byte 05 is handed off
    do_reset();
    for (int i = 0; i < 16; i++) fifo_push(8'(i));
    enable = 1'b1;
    n = 0;
    while (exp_bc < 16'd6 && n < 100) begin
      tick();
      n++;
    end
    chk("p4_reached_05", 32'(exp_bc >= 16'd6), 32'd1);
    enable = 1'b0;
    repeat (5) begin
      tick();
      chk("p4_gap_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    end
    enable = 1'b1;
    wait_drain(100, n);
    chk("p4_byte_count", 32'(byte_count), 32'd16);

    // Reset with two bytes buffered and one in flight
    do_reset();
    for (int i = 0; i < 8; i++) fifo_push(8'hA0 + 8'(i));
    enable = 1'b1;
    bus.m_ready = 1'b0;
    n = 0;
    while (!(outstanding == 3 && model_inflight == 1) && n < 50) begin
      tick();
      n++;
    end
    chk("p5_reached_full", 32'(outstanding), 32'd3);
    reset = 1'b0;
    #1;
    chk("p5_rd_en_in_reset", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    reset = 1'b1;
    chk("p5_m_valid", 32'(bus.m_valid), 32'd0);
    chk("p5_busy", 32'(busy), 32'd0);
    chk("p5_byte_count", 32'(byte_count), 32'd0);
    chk("p5_m_data", 32'(bus.m_data), 32'h00);
    bus.m_ready = 1'b1;

    // Randomised traffic, enable and back-pressure
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom % 8) != 0;
      bus.m_ready = ($urandom % 4) != 0;
      if (($urandom % 2) == 1 && fifo_q.size() < FIFO_CAP) fifo_push(8'($urandom));
      tick();
    end
    enable = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(200, n);
    tick();
    chk("p6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // byte_count wrap after 65536 hand-offs
    do_reset();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    pushed = 0;
    n = 0;
    while ((pushed < 65536 || fifo_q.size() != 0 || outstanding != 0) && n < 70000) begin
      while (pushed < 65536 && fifo_q.size() < FIFO_CAP) begin
        fifo_push(8'(pushed));
        pushed++;
      end
      tick();
      n++;
    end
    chk("p7_in_time", 32'(n < 70000), 32'd1);
    chk("p7_delivered", 32'(delivered), 32'd65536);
    chk("p7_byte_count_wrap", 32'(byte_count), 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
